overlay_compositor: RTL and testbench
=====================================

# overlay_compositor

Parametrised, pipelined pixel compositor that stacks `NUM_LAYERS` overlay layers over a base video pixel and adds a frame-timed judgment flash. It sits between the camera/threshold path and the HDMI output stage and is the generalised replacement for the fixed two-level background/target mux. Output is registered with a fixed two-cycle latency. A hardware state machine, rather than a per-pixel combinational flag, controls how long the flash stays visible.

## Interface
Parameters:
- `NUM_LAYERS`, default 4: number of overlay layers; layer `NUM_LAYERS-1` is topmost.
- `COLOR_W`, default 8: bits per colour channel; a pixel is `3*COLOR_W` bits, RGB with R in the MSBs.
- `FLASH_FRAMES`, default 30: number of frames the flash stays visible per trigger; must be ≥1.

Ports:
- `clk_pixel_in`  in  1  pixel clock; the only clock.
- `rst_in`  in  1  asynchronous, active-high reset.
- `valid_in`  in  1  input pixel qualifier.
- `frame_start_in`  in  1  one-cycle pulse at frame start; sampled regardless of `valid_in`.
- `base_pixel_in`  in  `3*COLOR_W`  bottom-layer pixel.
- `layer_pixel_in`  in  `NUM_LAYERS*3*COLOR_W`  layer *i* occupies slice `[i*3*COLOR_W +: 3*COLOR_W]`.
- `layer_hit_in`  in  `NUM_LAYERS`  per-pixel coverage of each layer.
- `layer_mask_in`  in  `NUM_LAYERS`  static layer enables.
- `layer_blend_in`  in  `NUM_LAYERS`  per-layer 50% blend select; only effective with `OVERLAY_BLEND_EN`.
- `flash_trigger_in`  in  1  one-cycle judgment event.
- `flash_correct_in`  in  1  judgment result; qualified by `flash_trigger_in`.
- `flash_region_in`  in  1  per-pixel flash coverage.
- `pixel_out`  out  `3*COLOR_W`  composited pixel.
- `valid_out`  out  1  `valid_in` delayed by 2 cycles.
- `flash_active_out`  out  1  high while the flash FSM is in SHOW.

## Operation
**Layer selection (stage 1)**
- Layer *i* is a candidate when `layer_hit_in[i] & layer_mask_in[i]` is set and its pixel is non-zero. An all-zero pixel is transparent.
- Among candidates, the highest index wins. If there is no candidate, the base pixel is selected.
- Stage 1 registers the winner index, a winner-valid bit, the winner pixel, the base pixel, the winner's blend bit, and `flash_region_in`.

**Output (stage 2), in priority order**
1. Flash in SHOW and registered region set: output the flash colour. Correct is blue (`0000FF` scaled to `COLOR_W`, i.e. B channel all ones). Wrong is red (R channel all ones).
2. Winner present: output the winner pixel, blended when `OVERLAY_BLEND_EN` applies.
3. Otherwise: output the base pixel.

**Pipeline registers**
- Data registers load only on cycles where the corresponding stage's valid bit is high; otherwise they hold.
- The valid shift chain advances every cycle.

**Flash FSM**
- States: IDLE, ARMED, SHOW. Counter width is `$clog2(FLASH_FRAMES+1)`.
- IDLE: a trigger latches the colour and moves to ARMED.
- ARMED: a trigger re-latches the colour. On `frame_start_in`, move to SHOW and load counter = `FLASH_FRAMES`.
- SHOW: on `frame_start_in`, if counter = 1 go to IDLE; else decrement. A trigger reloads counter = `FLASH_FRAMES`, re-latches the colour, and stays in SHOW.
- Trigger and frame_start in the same cycle:
  - In IDLE or ARMED, the trigger wins: go to or stay in ARMED. The flash starts at the next frame_start.
  - In SHOW, the reload wins over the decrement or exit.
- The flash therefore always covers exactly `FLASH_FRAMES` whole frames, starting at a frame boundary.

## Timing
- Latency from `valid_in` to `valid_out`/`pixel_out` is 2 cycles, with throughput of 1 pixel per cycle.
- The flash state is applied at stage 2 using the FSM state in that cycle. A SHOW entry caused by frame_start at cycle *t* affects pixels that entered at *t-1* onward.
- `flash_active_out` is registered FSM state: it rises the cycle after the qualifying frame_start.
- Reset values: `pixel_out`=0, `valid_out`=0, `flash_active_out`=0, FSM=IDLE, counter=0, latched colour=red, all pipeline registers 0.
- Reset asserted mid-frame or mid-flash clears everything immediately. After release, the block waits for a new trigger.

## Configuration
- `OVERLAY_BLEND_EN` defined: when the winner's blend bit is set, each output channel is `(layer_ch + base_ch) >> 1`. The add is computed at `COLOR_W+1` bits and truncates, with no rounding. The blend always mixes with the base, never with lower layers. Flash and base-only outputs are never blended.
- `OVERLAY_BLEND_EN` undefined: `layer_blend_in` is ignored and no adder logic is generated.

## Test plan
- Reset, then 4 valid pixels with no hits → `valid_out` high 2 cycles after `valid_in`; `pixel_out` equals the base pixels in order.
- Layers 1 and 3 hit, both masked on, layer 3 pixel `00FF00` → output `00FF00`. With layer 3 masked off → output is the layer 1 pixel. With layer 3 pixel = 0 → output is the layer 1 pixel.
- Trigger with correct=1 mid-frame, region held high, `FLASH_FRAMES`=2 → no flash until the next frame_start. Then `0000FF` for exactly 2 frames, and `flash_active_out` falls the cycle after the 3rd frame_start.
- Trigger in the same cycle as frame_start while IDLE → ARMED only. The flash begins at the following frame_start. A retrigger with correct=0 during SHOW → colour becomes `FF0000` and the counter reloads.
- With `OVERLAY_BLEND_EN`: winner `FF0000` with blend bit set over base `0000FE` → `7F007F`. Without the macro → `FF0000`.
- Assert `rst_in` for 1 cycle during SHOW with a full pipeline → outputs 0 immediately, FSM is IDLE, and no flash appears until a new trigger.

Source files
------------

// File: rtl/overlay_compositor.sv
// Two-stage pixel compositor: NUM_LAYERS overlay layers over a base pixel plus a frame-timed flash.
// Optional 50% layer/base blend is built only when OVERLAY_BLEND_EN is defined.
module overlay_compositor #(
  parameter int NUM_LAYERS   = 4,
  parameter int COLOR_W      = 8,
  parameter int FLASH_FRAMES = 30
) (
  input  logic                            clk_pixel_in,
  input  logic                            rst_in,
  input  logic                            valid_in,
  input  logic                            frame_start_in,
  input  logic [3*COLOR_W-1:0]            base_pixel_in,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_pixel_in,
  input  logic [NUM_LAYERS-1:0]           layer_hit_in,
  input  logic [NUM_LAYERS-1:0]           layer_mask_in,
  input  logic [NUM_LAYERS-1:0]           layer_blend_in,
  input  logic                            flash_trigger_in,
  input  logic                            flash_correct_in,
  input  logic                            flash_region_in,
  output logic [3*COLOR_W-1:0]            pixel_out,
  output logic                            valid_out,
  output logic                            flash_active_out
);

  localparam int PIX_W = 3 * COLOR_W;
  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int CNT_W = $clog2(FLASH_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLASH_FRAMES);

  typedef enum logic [1:0] {IDLE, ARMED, SHOW} flash_state_e;

  // Stage 1 state
  logic             v1_q;
  logic [IDX_W-1:0] win_idx_q,  win_idx_d;
  logic             win_vld_q,  win_vld_d;
  logic [PIX_W-1:0] win_pix_q,  win_pix_d;
  logic [PIX_W-1:0] base_q;
  logic             win_blend_q, win_blend_d;
  logic             region_q;

  // Stage 2 state
  logic             v2_q;
  logic [PIX_W-1:0] pix_q, pix_d;

  // Flash FSM state
  flash_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             correct_q, correct_d;

  // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    win_vld_d   = 1'b0;
    win_idx_d   = '0;
    win_pix_d   = '0;
    win_blend_d = 1'b0;
    // Ascending scan: the last candidate found is the highest index, which is topmost.
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (layer_hit_in[i] && layer_mask_in[i] && |layer_pixel_in[i*PIX_W +: PIX_W]) begin
        win_vld_d   = 1'b1;
        win_idx_d   = IDX_W'(i);
        win_pix_d   = layer_pixel_in[i*PIX_W +: PIX_W];
        win_blend_d = layer_blend_in[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    correct_d = correct_q;
    case (state_q)
      IDLE: begin
        if (flash_trigger_in) begin
          state_d   = ARMED;
          correct_d = flash_correct_in;
        end
      end
      ARMED: begin
        if (flash_trigger_in) begin
          correct_d = flash_correct_in;
        end else if (frame_start_in) begin
          state_d = SHOW;
          cnt_d   = CNT_LOAD;
        end
      end
      SHOW: begin
        if (flash_trigger_in) begin
          cnt_d     = CNT_LOAD;
          correct_d = flash_correct_in;
        end else if (frame_start_in) begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  logic [PIX_W-1:0] flash_pix;
  logic [PIX_W-1:0] layer_pix;

  assign flash_pix = correct_d ? {{(2*COLOR_W){1'b0}}, {COLOR_W{1'b1}}}
                               : {{COLOR_W{1'b1}}, {(2*COLOR_W){1'b0}}};

`ifdef OVERLAY_BLEND_EN
  logic [PIX_W-1:0] blend_pix;
  always_comb begin
    blend_pix = '0;
    for (int c = 0; c < 3; c++) begin
      logic [COLOR_W:0] sum;
      sum = {1'b0, win_pix_q[c*COLOR_W +: COLOR_W]} + {1'b0, base_q[c*COLOR_W +: COLOR_W]};
      blend_pix[c*COLOR_W +: COLOR_W] = sum[COLOR_W:1];
    end
  end
  assign layer_pix = win_blend_q ? blend_pix : win_pix_q;
`else
  logic unused_blend;
  assign unused_blend = win_blend_q;
  assign layer_pix    = win_pix_q;
`endif

  // The next FSM state is used so a SHOW entry on frame_start also covers the pixel already in stage 1.
  always_comb begin
    if (state_d == SHOW && region_q) begin
      pix_d = flash_pix;
    end else if (win_vld_q) begin
      pix_d = layer_pix;
    end else begin
      pix_d = base_q;
    end
  end

  logic unused_idx;
  assign unused_idx = ^win_idx_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      v1_q        <= 1'b0;
      win_idx_q   <= '0;
      win_vld_q   <= 1'b0;
      win_pix_q   <= '0;
      base_q      <= '0;
      win_blend_q <= 1'b0;
      region_q    <= 1'b0;
      v2_q        <= 1'b0;
      pix_q       <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      correct_q   <= 1'b0;
    end else begin
      v1_q      <= valid_in;
      v2_q      <= v1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      correct_q <= correct_d;
      if (valid_in) begin
        win_idx_q   <= win_idx_d;
        win_vld_q   <= win_vld_d;
        win_pix_q   <= win_pix_d;
        base_q      <= base_pixel_in;
        win_blend_q <= win_blend_d;
        region_q    <= flash_region_in;
      end
      if (v1_q) begin
        pix_q <= pix_d;
      end
    end
  end

  assign pixel_out        = pix_q;
  assign valid_out        = v2_q;
  assign flash_active_out = (state_q == SHOW);

endmodule

// File: tb/tb_overlay_compositor.sv
// Directed bench for overlay_compositor (NUM_LAYERS=4, COLOR_W=8, FLASH_FRAMES=2).
// Blend expectations follow OVERLAY_BLEND_EN when it is defined for the build.
module tb_overlay_compositor;

  localparam int NL = 4;
  localparam int CW = 8;
  localparam int PW = 3 * CW;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_in, frame_start, trig, correct, region;
  logic [PW-1:0]   base;
  logic [NL*PW-1:0] layers;
  logic [NL-1:0]   hit, mask, blend;
  logic [PW-1:0]   pixel_out;
  logic            valid_out, flash_active;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  overlay_compositor #(.NUM_LAYERS(NL), .COLOR_W(CW), .FLASH_FRAMES(2)) dut (
    .clk_pixel_in    (clk),
    .rst_in          (rst),
    .valid_in        (valid_in),
    .frame_start_in  (frame_start),
    .base_pixel_in   (base),
    .layer_pixel_in  (layers),
    .layer_hit_in    (hit),
    .layer_mask_in   (mask),
    .layer_blend_in  (blend),
    .flash_trigger_in(trig),
    .flash_correct_in(correct),
    .flash_region_in (region),
    .pixel_out       (pixel_out),
    .valid_out       (valid_out),
    .flash_active_out(flash_active)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One pixel through the pipeline, checked once it reaches the output.
  task automatic send(input string tag, input logic [PW-1:0] exp);
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    step();
    check(tag, 32'(pixel_out), 32'(exp));
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic trigger(input logic c, input logic with_fs);
    trig        = 1'b1;
    correct     = c;
    frame_start = with_fs;
    step();
    trig        = 1'b0;
    frame_start = 1'b0;
  endtask

  localparam logic [PW-1:0] BLUE = 24'h0000FF;
  localparam logic [PW-1:0] RED  = 24'hFF0000;

  initial begin
    logic [PW-1:0] bases [4];
    logic [PW-1:0] blend_exp;
    bases[0] = 24'h112233; bases[1] = 24'h445566;
    bases[2] = 24'h778899; bases[3] = 24'hAABBCC;

    rst = 1'b1; valid_in = 0; frame_start = 0; trig = 0; correct = 0; region = 0;
    base = '0; layers = '0; hit = '0; mask = '0; blend = '0;
    repeat (3) step();
    check("rst_pix",   32'(pixel_out), 32'h0);
    check("rst_valid", 32'(valid_out), 32'h0);
    check("rst_flash", 32'(flash_active), 32'h0);
    rst = 1'b0;
    step();

    // Base pass-through, pipelined back to back.
    for (int c = 0; c < 6; c++) begin
      valid_in = (c < 4);
      if (c < 4) base = bases[c];
      step();
      check($sformatf("valid_c%0d", c), 32'(valid_out), 32'((c >= 1) && (c <= 4)));
      if (c >= 1 && c <= 4) check($sformatf("base_c%0d", c), 32'(pixel_out), 32'(bases[c-1]));
    end
    valid_in = 1'b0;

    // Layer priority, masking, transparency.
    base   = 24'h010203;
    layers = {24'h00FF00, 24'h0, 24'h0A0B0C, 24'h0};
    hit    = 4'b1010;
    mask   = 4'b1111;
    send("top_layer", 24'h00FF00);
    mask   = 4'b0111;
    send("mask_off_l3", 24'h0A0B0C);
    mask   = 4'b1111;
    layers = {24'h0, 24'h0, 24'h0A0B0C, 24'h0};
    send("transparent_l3", 24'h0A0B0C);
    hit    = 4'b0010;
    mask   = 4'b1101;
    send("no_candidate", 24'h010203);

    // Blend of winner with base.
    layers = {24'h0, RED, 24'h0, 24'h0};
    hit    = 4'b0100;
    mask   = 4'b1111;
    blend  = 4'b0100;
    base   = 24'h0000FE;
`ifdef OVERLAY_BLEND_EN
    blend_exp = 24'h7F007F;
`else
    blend_exp = RED;
`endif
    send("blend", blend_exp);
    blend  = '0;
    hit    = '0;

    // Flash: trigger mid-frame, visible only from the next frame start for two frames.
    base   = 24'h123456;
    region = 1'b1;
    trigger(1'b1, 1'b0);
    check("armed_flag", 32'(flash_active), 32'h0);
    send("armed_pix", 24'h123456);
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    frame_pulse();
    check("show_edge_pix", 32'(pixel_out), 32'(BLUE));
    check("show_flag", 32'(flash_active), 32'h1);
    send("show_f1", BLUE);
    frame_pulse();
    check("show_flag_f2", 32'(flash_active), 32'h1);
    send("show_f2", BLUE);
    frame_pulse();
    check("exit_flag", 32'(flash_active), 32'h0);
    send("exit_pix", 24'h123456);

    // Trigger coincident with frame start in IDLE only arms; retrigger in SHOW reloads and recolours.
    trigger(1'b1, 1'b1);
    check("coinc_flag", 32'(flash_active), 32'h0);
    send("coinc_pix", 24'h123456);
    frame_pulse();
    check("coinc_show", 32'(flash_active), 32'h1);
    frame_pulse();
    check("before_retrig", 32'(flash_active), 32'h1);
    trigger(1'b0, 1'b0);
    send("retrig_red", RED);
    frame_pulse();
    check("reload_hold", 32'(flash_active), 32'h1);
    send("reload_red", RED);
    frame_pulse();
    check("reload_exit", 32'(flash_active), 32'h0);

    // Asynchronous reset during SHOW with a full pipeline.
    trigger(1'b1, 1'b0);
    frame_pulse();
    valid_in = 1'b1;
    step();
    step();
    check("prerst_pix", 32'(pixel_out), 32'(BLUE));
    rst = 1'b1;
    #1;
    check("async_pix",   32'(pixel_out), 32'h0);
    check("async_valid", 32'(valid_out), 32'h0);
    check("async_flash", 32'(flash_active), 32'h0);
    valid_in = 1'b0;
    step();
    rst = 1'b0;
    frame_pulse();
    check("post_rst_flag", 32'(flash_active), 32'h0);
    send("post_rst_pix", 24'h123456);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
